// File: rtl/mux_scan_ctrl_pkg.sv
// Shared types and constants for the mux scan sequencer.
package mux_scan_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned DWELL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl_decoder.sv
// 2-to-4 one-hot decoder.
module decoder (
  input  logic [1:0] s,
  output logic [3:0] o
);

  // One-hot decode of the select value.
  always_comb begin
    o    = '0;
    o[s] = 1'b1;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer upstream of a 4x1 mux: walks sel over channels 0..3, waits
// DWELL cycles per channel, samples mux_o once per channel and publishes the
// captured vector with a one-cycle done pulse.
// Optional: define MUX_SCAN_CHG_EN to add the `changed` output.
module mux_scan_ctrl #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DWELL  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mux_o,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] sample,
  output logic              valid
`ifdef MUX_SCAN_CHG_EN
  ,
  output logic              changed
`endif
);

  import mux_scan_pkg::*;

  if (NUM_CH != mux_scan_pkg::NUM_CH || SEL_W != mux_scan_pkg::SEL_W) begin : g_bad_width
    $error("mux_scan_ctrl: NUM_CH must be 4 and SEL_W must be 2");
  end

  if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be in 1..15");
  end

  localparam logic [DWELL_W-1:0] DWELL_LD = DWELL_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   SEL_LAST = SEL_W'(NUM_CH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWELL_W-1:0] r_cnt;
  logic [DWELL_W-1:0] w_cnt_nxt;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [NUM_CH-1:0] r_shadow;
  logic [NUM_CH-1:0] w_shadow_nxt;
  logic [NUM_CH-1:0] w_dec;
  logic [NUM_CH-1:0] w_we;
  logic              w_busy_nxt;
  logic              w_pub;

  decoder u_dec (
    .s (sel),
    .o (w_dec)
  );

  // Per-bit shadow write enables: decoded channel, only in SAMPLE.
  always_comb begin
    w_we = '0;
    if (r_state == SAMPLE) begin
      w_we = w_dec;
    end
  end

  // Next-state, counter, select and shadow computation.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_sel_nxt    = sel;
    w_shadow_nxt = r_shadow;
    case (r_state)
      IDLE, DONE: begin
        w_sel_nxt = '0;
        if (start) begin
          w_state_nxt  = SETTLE;
          w_cnt_nxt    = DWELL_LD;
          w_shadow_nxt = '0;
        end else begin
          w_state_nxt  = IDLE;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end
      end
      SAMPLE: begin
        for (int unsigned k = 0; k < NUM_CH; k++) begin
          if (w_we[k]) begin
            w_shadow_nxt[k] = mux_o;
          end
        end
        if (sel == SEL_LAST) begin
          w_state_nxt = DONE;
          w_sel_nxt   = '0;
        end else begin
          w_state_nxt = SETTLE;
          w_sel_nxt   = sel + SEL_W'(1);
          w_cnt_nxt   = DWELL_LD;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_sel_nxt   = '0;
      end
    endcase
  end

  // Registered outputs are loaded from the next state so they line up with
  // the state they describe; sample is taken from the completed next shadow
  // because the last channel's bit lands on the same edge that enters DONE.
  always_comb begin
    w_busy_nxt = (w_state_nxt == SETTLE) || (w_state_nxt == SAMPLE);
    w_pub      = (w_state_nxt == DONE);
  end

  // State, counter, select and shadow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      sel      <= '0;
      r_shadow <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      sel      <= w_sel_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  // Status and published-result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      sample <= '0;
      valid  <= 1'b0;
    end else begin
      busy <= w_busy_nxt;
      done <= w_pub;
      if (w_pub) begin
        sample <= w_shadow_nxt;
        valid  <= 1'b1;
      end
    end
  end

`ifdef MUX_SCAN_CHG_EN
  // Change flag: pulses with done when the new scan differs from the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
    end else begin
      changed <= w_pub && (w_shadow_nxt != sample);
    end
  end
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl with a scan-level reference model.
module tb_mux_scan_ctrl;

  localparam int D = 2;
  localparam int P = D + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] i_vec;
  logic       mux_o;
  logic [1:0] sel;
  logic       busy;
  logic       done;
  logic [3:0] sample;
  logic       valid;
`ifdef MUX_SCAN_CHG_EN
  logic       changed;
`endif

  always #5 clk = ~clk;

  // 4x1 mux in front of the sequencer.
  assign mux_o = i_vec[sel];

  mux_scan_ctrl #(.NUM_CH(4), .SEL_W(2), .DWELL(D)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .mux_o  (mux_o),
    .sel    (sel),
    .busy   (busy),
    .done   (done),
    .sample (sample),
    .valid  (valid)
`ifdef MUX_SCAN_CHG_EN
    ,
    .changed(changed)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         at_edge;
    logic [3:0] bits;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc        = 0;
  int         scan_start = -1;
  int         scan_end   = -1;
  int         k;
  logic [3:0] acc        = '0;
  logic [3:0] last_pub   = '0;
  logic       pub_any    = 1'b0;
  logic       busy_exp;
  logic       dexp;
  exp_t       e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: a scan accepted at edge n captures channel k from the
  // mux input present at edge n+(k+1)*(D+1) and publishes after edge n+4*(D+1).
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      scan_start = -1;
      scan_end   = -1;
    end else if (cyc > scan_end && start) begin
      scan_start = cyc;
      scan_end   = cyc + 4 * P;
      acc        = '0;
    end else if (scan_start >= 0 && cyc > scan_start && cyc <= scan_end &&
                 ((cyc - scan_start) % P) == 0) begin
      k      = (cyc - scan_start) / P - 1;
      acc[k] = i_vec[k];
      if (cyc == scan_end) exp_q.push_back('{cyc, acc});
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_pub = '0;
      pub_any  = 1'b0;
    end else begin
      busy_exp = (scan_start >= 0) && (cyc >= scan_start) && (cyc < scan_end);
      chk("busy", busy, busy_exp);
      chk("sel", sel, busy_exp ? (cyc - scan_start) / P : 0);
      while (exp_q.size() > 0 && exp_q[0].at_edge < cyc) void'(exp_q.pop_front());
      dexp = (exp_q.size() > 0) && (exp_q[0].at_edge == cyc);
      chk("done", done, dexp);
      if (dexp) begin
        e = exp_q.pop_front();
`ifdef MUX_SCAN_CHG_EN
        chk("changed", changed, e.bits != last_pub);
`endif
        last_pub = e.bits;
        pub_any  = 1'b1;
      end else begin
`ifdef MUX_SCAN_CHG_EN
        chk("changed_idle", changed, 0);
`endif
      end
      chk("sample", sample, last_pub);
      chk("valid", valid, pub_any);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic one_scan(input logic [3:0] v);
    i_vec = v;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(14);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sample"}, sample, 0);
    chk({tag, "_valid"}, valid, 0);
`ifdef MUX_SCAN_CHG_EN
    chk({tag, "_changed"}, changed, 0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    i_vec = '0;
    step(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    step(2);

    // Basic scan.
    one_scan(4'b1010);
    chk("basic_result", sample, 4'b1010);

    // Start pulses while busy are ignored.
    i_vec = 4'b0110;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(10);
    chk("busy_start_result", sample, 4'b0110);

    // Glitch on i[1] during channel 1 settle, stable only at its sample.
    i_vec = 4'b0000;
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      step(1);
      i_vec[1] = (c == 3 || c == 5);
    end
    chk("glitch_result", sample, 4'b0010);

    // Back-to-back scans with start held high.
    i_vec = 4'b1010;
    start = 1'b1;
    step(1);
    step(5);
    i_vec = 4'b0101;
    step(8);
    step(12);
    start = 1'b0;
    step(3);
    chk("b2b_result", sample, 4'b0101);

    // Change-detect sequence.
    one_scan(4'b0000);
    one_scan(4'b0000);
    one_scan(4'b0001);

    // Randomized start and mux inputs.
    repeat (400) begin
      start = ($urandom_range(0, 3) == 0);
      i_vec = 4'($urandom);
      step(1);
    end
    start = 1'b0;
    step(15);

    // Asynchronous reset in the middle of channel 2 settle.
    i_vec = 4'b1111;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("post_rst_sel", sel, 0);
    chk("post_rst_busy", busy, 0);
    one_scan(4'b0110);
    chk("post_rst_result", sample, 4'b0110);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
